matrix_keypad_ctrl: RTL and testbench

MATRIX_KEYPAD_CTRL -- requirements
Module: matrix_keypad_ctrl

---
 rtl/matrix_keypad_ctrl_if.sv | 18 +
 rtl/matrix_keypad_ctrl.sv | 179 +++++++++++++++++
 tb/tb_matrix_keypad_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_keypad_ctrl_if.sv
// ---------------------------------------------------------------------------
// matrix_keypad_ctrl_if
// Accepted-key handshake between the keypad scanner and its consumer.
//   key_valid : a key code is waiting (scanner -> consumer)
//   key_ready : consumer takes the code this cycle (consumer -> scanner)
//   key_code  : code of the waiting key, r*COLS + c (scanner -> consumer)
// KW must match the scanner's key code width, clog2(ROWS*COLS).
// ---------------------------------------------------------------------------
interface matrix_keypad_ctrl_if #(
    parameter int KW = 4
);
    logic          key_valid;
    logic          key_ready;
    logic [KW-1:0] key_code;

    modport master (output key_valid, output key_code, input key_ready);
    modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/matrix_keypad_ctrl.sv
// ---------------------------------------------------------------------------
// matrix_keypad_ctrl
// Scans a ROWS x COLS switch matrix, debounces press and release, and hands
// each accepted key out over a valid/ready handshake while also keeping a
// shift-register history of the last DIGITS codes.
//   clk     : sole clock, rising edge
//   rst     : asynchronous active-low reset
//   row_in  : active-low row sense, all ones = no key
//   col_out : active-low one-hot column drive
//   kif     : key_valid / key_ready / key_code handshake (master side)
//   data    : code history, newest code in [KW-1:0]
//   clr     : synchronous clear of data and overrun
//   overrun : sticky flag, a key was accepted while the previous one was
//             still waiting
// ---------------------------------------------------------------------------
module matrix_keypad_ctrl #(
    parameter  int ROWS     = 4,
    parameter  int COLS     = 4,
    parameter  int DBNC_CYC = 24'hFFFFFF,
    parameter  int SCAN_DIV = 16,
    parameter  int DIGITS   = 4,
    localparam int KW       = (ROWS * COLS > 2) ? $clog2(ROWS * COLS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ROWS-1:0]        row_in,
    output logic [COLS-1:0]        col_out,
    matrix_keypad_ctrl_if.master   kif,
    output logic [DIGITS*KW-1:0]   data,
    input  logic                   clr,
    output logic                   overrun
);
    localparam int CW  = $clog2(DBNC_CYC);
    localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CIW = $clog2(COLS);
    localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] PRESS_DB = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;
    localparam logic [1:0] REL_DB   = 2'd3;

    logic [1:0]          r_state;
    logic [CW-1:0]       r_cnt;
    logic [DW-1:0]       r_div;
    logic [CIW-1:0]      r_col;
    logic [ROWS-1:0]     r_latch;
    logic [DIGITS*KW-1:0] r_data;
    logic [KW-1:0]       r_code;
    logic                r_valid;
    logic                r_ovr;

    logic                w_idle;
    logic                w_accept;
    logic [CIW-1:0]      w_col_next;
    logic [RIW-1:0]      w_row_idx;
    logic [KW-1:0]       w_new_code;
    logic [DIGITS*KW-1:0] w_shift;

    assign w_idle     = &row_in;
    assign w_col_next = (r_col == CIW'(COLS - 1)) ? '0 : r_col + 1'b1;
    // Accept on the last debounce cycle, provided the row pattern still holds.
    assign w_accept   = (r_state == PRESS_DB) && (row_in == r_latch) &&
                        (r_cnt == CW'(DBNC_CYC - 1));

    // Lowest-index low row wins when several rows are pressed together.
    always_comb begin
        w_row_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--)
            if (!r_latch[i]) w_row_idx = RIW'(i);
    end

    assign w_new_code = KW'(int'(w_row_idx) * COLS + int'(r_col));

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            assign col_out[gi] = (r_col != CIW'(gi));
        end
        for (gi = 0; gi < DIGITS; gi++) begin : g_shift
            if (gi == 0) begin : g_new
                assign w_shift[KW-1:0] = w_new_code;
            end else begin : g_old
                assign w_shift[gi*KW +: KW] = r_data[(gi-1)*KW +: KW];
            end
        end
    endgenerate

    // Scan / debounce FSM. The column only moves while idle in SCAN or on
    // leaving REL_DB, so the row pattern stays tied to one column throughout
    // a debounce.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SCAN;
            r_cnt   <= '0;
            r_div   <= '0;
            r_col   <= '0;
            r_latch <= '1;
        end else begin
            case (r_state)
                SCAN: begin
                    if (w_idle) begin
                        if (r_div == DW'(SCAN_DIV - 1)) begin
                            r_div <= '0;
                            r_col <= w_col_next;
                        end else begin
                            r_div <= r_div + 1'b1;
                        end
                    end else begin
                        r_latch <= row_in;
                        r_cnt   <= '0;
                        r_div   <= '0;
                        r_state <= PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (row_in != r_latch)
                        r_state <= SCAN;
                    else if (r_cnt == CW'(DBNC_CYC - 1))
                        r_state <= HELD;
                    else
                        r_cnt <= r_cnt + 1'b1;
                end
                HELD: begin
                    if (w_idle) begin
                        r_cnt   <= '0;
                        r_state <= REL_DB;
                    end
                end
                REL_DB: begin
                    if (!w_idle) begin
                        r_state <= HELD;
                    end else if (r_cnt == CW'(DBNC_CYC - 1)) begin
                        r_state <= SCAN;
                        r_col   <= w_col_next;
                        r_div   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

    // Handshake, history and overrun. A key that arrives while the previous
    // one is still unclaimed keeps the old code visible but is still logged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_accept) begin
                if (!r_valid || kif.key_ready) begin
                    r_code  <= w_new_code;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && kif.key_ready) begin
                r_valid <= 1'b0;
            end

            if (clr) begin
                r_ovr  <= 1'b0;
                r_data <= w_accept ? (DIGITS*KW)'(w_new_code) : '0;
            end else if (w_accept) begin
                r_data <= w_shift;
            end
        end
    end

    assign kif.key_valid = r_valid;
    assign kif.key_code  = r_code;
    assign data          = r_data;
    assign overrun       = r_ovr;
endmodule

// File: tb/tb_matrix_keypad_ctrl.sv
`timescale 1ns/1ps
module tb_matrix_keypad_ctrl;
    localparam int DBNC = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- DUT 1: 4x4, DBNC 8, SCAN_DIV 2 ----------------
    logic [3:0]  row_in, col_out;
    logic [15:0] data;
    logic        clr = 1'b0;
    logic        overrun;
    logic [3:0]  press_mask = '0;
    int          press_col  = 0;

    matrix_keypad_ctrl_if #(.KW(4)) kif ();
    matrix_keypad_ctrl #(.ROWS(4), .COLS(4), .DBNC_CYC(DBNC), .SCAN_DIV(2), .DIGITS(4)) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out), .kif(kif),
        .data(data), .clr(clr), .overrun(overrun));

    // Physical switch matrix: a pressed key pulls its row low only while its
    // column is being driven.
    always_comb row_in = (press_mask != 4'h0 && col_out[press_col] == 1'b0) ? ~press_mask : 4'hF;

    // ---------------- DUT 2: 2x8, DIGITS 2 ----------------
    logic [1:0] row_in2;
    logic [7:0] col_out2;
    logic [7:0] data2;
    logic       clr2 = 1'b0;
    logic       overrun2;
    logic [1:0] press2_mask = '0;
    int         press2_col  = 0;

    matrix_keypad_ctrl_if #(.KW(4)) kif2 ();
    matrix_keypad_ctrl #(.ROWS(2), .COLS(8), .DBNC_CYC(DBNC), .SCAN_DIV(2), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .row_in(row_in2), .col_out(col_out2), .kif(kif2),
        .data(data2), .clr(clr2), .overrun(overrun2));

    always_comb row_in2 = (press2_mask != 2'b0 && col_out2[press2_col] == 1'b0) ? ~press2_mask : 2'b11;

    // ---------------- Behavioural model of DUT 1 ----------------
    // A key is taken once the same non-idle row pattern has been seen for
    // DBNC+1 consecutive samples while unlocked; the lock releases after
    // DBNC+1 consecutive idle samples.
    typedef struct packed {
        logic        locked;
        logic [7:0]  run;
        logic [7:0]  idle;
        logic [3:0]  prev;
        logic        valid;
        logic [3:0]  code;
        logic        ov;
        logic [15:0] data;
        logic [15:0] accepts;
    } mdl_t;

    localparam mdl_t MDL_RST = '{locked: 1'b0, run: 8'd0, idle: 8'd0, prev: 4'hF,
                                 valid: 1'b0, code: 4'd0, ov: 1'b0, data: 16'd0, accepts: 16'd0};
    mdl_t m;

    function automatic mdl_t step(input mdl_t cur, input logic [3:0] s, input logic rdy,
                                  input logic c, input int pcol);
        mdl_t n;
        logic acc;
        logic [3:0] cn;
        int lr;
        n   = cur;
        acc = 1'b0;
        lr  = 0;
        for (int i = 3; i >= 0; i--) if (!s[i]) lr = i;
        cn = 4'(lr * 4 + pcol);
        if (!cur.locked) begin
            if (s != 4'hF) begin
                n.run = (s == cur.prev) ? cur.run + 8'd1 : 8'd1;
                if (n.run == 8'(DBNC + 1)) begin
                    acc      = 1'b1;
                    n.locked = 1'b1;
                    n.idle   = 8'd0;
                end
            end else begin
                n.run = 8'd0;
            end
        end else begin
            if (s == 4'hF) begin
                n.idle = cur.idle + 8'd1;
                if (n.idle == 8'(DBNC + 1)) begin
                    n.locked = 1'b0;
                    n.run    = 8'd0;
                end
            end else begin
                n.idle = 8'd0;
            end
        end
        n.prev = s;
        if (acc) begin
            if (!cur.valid || rdy) begin
                n.valid = 1'b1;
                n.code  = cn;
            end else begin
                n.ov = 1'b1;
            end
            n.data    = (cur.data << 4) | 16'(cn);
            n.accepts = cur.accepts + 16'd1;
        end else if (cur.valid && rdy) begin
            n.valid = 1'b0;
        end
        if (c) begin
            n.ov   = 1'b0;
            n.data = acc ? 16'(cn) : 16'd0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= MDL_RST;
        else      m <= step(m, row_in, kif.key_ready, clr, press_col);
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            check("key_valid", kif.key_valid, m.valid);
            check("key_code", kif.key_code, m.code);
            check("overrun", overrun, m.ov);
            check("data", data, m.data);
            check("col_onehot", $countones(~col_out), 1);
        end
    end

    // Rising edges of key_valid on DUT 1.
    int   n_rise = 0;
    logic v_prev = 1'b0;
    initial forever begin
        @(negedge clk);
        if (kif.key_valid && !v_prev) n_rise++;
        v_prev = kif.key_valid;
    end

    // Watchdog: every wait below is bounded; this only guards the unexpected.
    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    bit rand_on = 1'b0;
    task automatic step_cycle();
        @(negedge clk);
        if (rand_on) begin
            kif.key_ready = ($urandom_range(0, 3) != 0);
            clr           = ($urandom_range(0, 63) == 0);
        end
    endtask

    task automatic wait_row();
        for (int t = 0; t < 40; t++) begin
            if (row_in != 4'hF) break;
            @(negedge clk);
        end
        check("row_seen", row_in != 4'hF, 1'b1);
    endtask

    // Latency from the first low-row cycle to key_valid, in cycles.
    task automatic wait_key(output int lat);
        lat = -1;
        wait_row();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (kif.key_valid) begin
                lat = k;
                break;
            end
        end
        check("key_seen", lat > 0, 1'b1);
    endtask

    initial begin
        int lat;
        int r0;
        int clean_cnt;
        logic [15:0] acc0;
        logic [3:0]  c0;
        logic [7:0]  c2;
        logic [3:0]  code_seen;

        kif.key_ready  = 1'b1;
        kif2.key_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_col_out", col_out, 4'b1110);
        check("rst_key_valid", kif.key_valid, 1'b0);
        check("rst_key_code", kif.key_code, 4'd0);
        check("rst_data", data, 16'd0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_col_out2", col_out2, 8'hFE);
        rst = 1'b1;
        @(negedge clk);

        // Row 2 on column 1, held ~20 cycles
        kif.key_ready = 1'b0;
        r0 = n_rise;
        press_col = 1; press_mask = 4'b0100;
        wait_key(lat);
        $display("press r2c1: latency %0d code %0h data %0h", lat, kif.key_code, data);
        check("press_latency", (lat >= 9 && lat <= 11), 1'b1);
        check("press_code", kif.key_code, 4'd9);
        check("press_data", data, 16'h0009);
        check("model_code_9", m.code, 4'd9);
        repeat (10) @(negedge clk);
        check("press_single", n_rise - r0, 1);
        press_mask = 4'h0;
        kif.key_ready = 1'b1;
        repeat (20) @(negedge clk);

        // Bounce: toggling every 3 cycles for 30 cycles
        r0 = n_rise;
        for (int i = 0; i < 10; i++) begin
            press_mask = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            repeat (3) @(negedge clk);
        end
        press_mask = 4'h0;
        c0 = col_out;
        lat = 0;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            if (col_out != c0) begin lat = t; break; end
        end
        $display("bounce: rises %0d, scan resumed after %0d", n_rise - r0, lat);
        check("bounce_no_key", n_rise - r0, 0);
        check("bounce_scan_resumed", lat > 0, 1'b1);

        // Two presses without consumer: overrun, then clear
        kif.key_ready = 1'b0;
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        press_col = 1; press_mask = 4'b0001;
        wait_key(lat);
        repeat (4) @(negedge clk);
        press_mask = 4'h0;
        repeat (20) @(negedge clk);
        press_col = 2; press_mask = 4'b0010;
        for (int t = 0; t < 60 && !overrun; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        press_mask = 4'h0;
        repeat (20) @(negedge clk);
        $display("overrun: code %0h ovr %0b data %0h", kif.key_code, overrun, data);
        check("ovr_code", kif.key_code, 4'd1);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_data", data, 16'h0016);
        check("model_data_0016", m.data, 16'h0016);
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        $display("clr: data %0h ovr %0b valid %0b", data, overrun, kif.key_valid);
        check("clr_data", data, 16'd0);
        check("clr_overrun", overrun, 1'b0);
        check("clr_valid_kept", kif.key_valid, 1'b1);
        kif.key_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Rows 1 and 3 together on column 0, held 100 cycles
        kif.key_ready = 1'b0;
        r0 = n_rise;
        press_col = 0; press_mask = 4'b1010;
        wait_key(lat);
        code_seen = kif.key_code;
        repeat (100) @(negedge clk);
        press_mask = 4'h0;
        $display("two rows: code %0h rises %0d", code_seen, n_rise - r0);
        check("multirow_code", code_seen, 4'd4);
        check("multirow_single", n_rise - r0, 1);
        check("model_code_4", m.code, 4'd4);
        repeat (20) @(negedge clk);

        // Reset in the middle of a press debounce, key_valid still high
        press_col = 1; press_mask = 4'b0100;
        wait_row();
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        $display("async reset: col %0b valid %0b", col_out, kif.key_valid);
        check("async_rst_col", col_out, 4'b1110);
        check("async_rst_valid", kif.key_valid, 1'b0);
        press_mask = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        kif.key_ready = 1'b1;
        r0 = n_rise;
        repeat (40) @(negedge clk);
        check("post_rst_no_key", n_rise - r0, 0);
        check("post_rst_data", data, 16'd0);

        // Randomised presses and bounces against the model
        rand_on   = 1'b1;
        clean_cnt = 0;
        acc0      = m.accepts;
        for (int e = 0; e < 40; e++) begin
            int   col, nb;
            logic [3:0] mask;
            bit   clean;
            col   = $urandom_range(0, 3);
            mask  = 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 1) != 0) mask = mask | 4'(1 << $urandom_range(0, 3));
            clean = ($urandom_range(0, 2) != 0);
            press_col = col;
            if (clean) begin
                clean_cnt++;
                press_mask = mask;
                repeat ($urandom_range(25, 60)) step_cycle();
            end else begin
                nb = $urandom_range(3, 8);
                for (int k = 0; k < nb; k++) begin
                    press_mask = mask;
                    repeat ($urandom_range(1, 5)) step_cycle();
                    press_mask = 4'h0;
                    repeat ($urandom_range(1, 5)) step_cycle();
                end
            end
            press_mask = 4'h0;
            repeat (30) step_cycle();
            $display("event %0d: col %0d mask %0h clean %0b data %0h ovr %0b", e, col, mask, clean, data, overrun);
        end
        rand_on = 1'b0;
        kif.key_ready = 1'b1;
        clr = 1'b0;
        repeat (5) @(negedge clk);
        check("random_accept_count", m.accepts - acc0, clean_cnt);

        // 2x8 variant: row 1 on column 7
        press2_col = 7; press2_mask = 2'b10;
        for (int t = 0; t < 40 && row_in2 == 2'b11; t++) @(negedge clk);
        check("row2_seen", row_in2 != 2'b11, 1'b1);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (kif2.key_valid) begin lat = k; break; end
        end
        $display("2x8 press: code %0h data %0h", kif2.key_code, data2);
        check("dut2_key_seen", lat > 0, 1'b1);
        check("dut2_code", kif2.key_code, 4'd15);
        check("dut2_data", data2, 8'h0F);
        repeat (5) @(negedge clk);
        press2_mask = 2'b00;
        c2 = col_out2;
        for (int t = 0; t < 40 && col_out2 == c2; t++) @(negedge clk);
        $display("2x8 release: col %0h", col_out2);
        check("dut2_col_wrap", col_out2, 8'hFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
